// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
// Iterative multiply/divide unit for the EX stage. A shift-add multiplier and
// a restoring divider share one set of working registers and take one cycle
// per result bit. While an operation is pending the pipeline front end is
// frozen through Stall_o. The result is then presented with a one-cycle Done_o
// pulse so the EX/MEM latch can capture it.
//
// Optional feature macro: MULDIV_HILO_EN
//    When it is defined, the Hi_o port carries one of two values:
//       - the upper product word for MUL/MULU
//       - the remainder for DIV/DIVU
//
// Ports
//    Clock_i    in   1      clock, all state changes on posedge
//    Reset_i    in   1      synchronous active-high reset
//    Start_i    in   1      operation request, only looked at in IDLE
//    Op_i       in   2      00 MUL, 01 MULU, 10 DIV, 11 DIVU
//    Data1_i    in   WIDTH  multiplicand / dividend
//    Data2_i    in   WIDTH  multiplier / divisor
//    Result_o   out  WIDTH  low product word or quotient (held between ops)
//    Stall_o    out  1      freeze upstream pipeline while op is pending
//    Done_o     out  1      one-cycle result-valid pulse
//    DivZero_o  out  1      qualifies Done_o: divide had a zero divisor
//    Hi_o       out  WIDTH  upper product / remainder (MULDIV_HILO_EN only)
// ---------------------------------------------------------------------------
module ex_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clock_i,
   input  logic             Reset_i,
   input  logic             Start_i,
   input  logic [1:0]       Op_i,
   input  logic [WIDTH-1:0] Data1_i,
   input  logic [WIDTH-1:0] Data2_i,
   output logic [WIDTH-1:0] Result_o,
   output logic             Stall_o,
   output logic             Done_o,
   output logic             DivZero_o
`ifdef MULDIV_HILO_EN
   ,output logic [WIDTH-1:0] Hi_o
`endif
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_b;
   logic             r_isdiv;
   logic             r_divz;
   logic             r_negres;
`ifdef MULDIV_HILO_EN
   logic             r_negrem;
`endif

   logic             w_signed;
   logic             w_aneg;
   logic             w_bneg;
   logic [WIDTH-1:0] w_amag;
   logic [WIDTH-1:0] w_bmag;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH-1:0] w_hi_nxt;
   logic [WIDTH-1:0] w_lo_nxt;
   logic [WIDTH-1:0] w_result;
`ifdef MULDIV_HILO_EN
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_hiresult;
`endif

   // Op_i[0] set means unsigned. Signed operands are reduced to magnitudes so
   // that a single unsigned core serves all four operations.
   always_comb begin
      w_signed = ~Op_i[0];
      w_aneg   = w_signed & Data1_i[WIDTH-1];
      w_bneg   = w_signed & Data2_i[WIDTH-1];
      w_amag   = w_aneg ? -Data1_i : Data1_i;
      w_bmag   = w_bneg ? -Data2_i : Data2_i;
   end

   // One iteration of the shared core.
   // Multiply: r_lo holds the multiplier, and the product shifts in from the
   // top of {r_hi, r_lo}.
   // Divide: r_lo holds the dividend and collects quotient bits, and r_hi is
   // the partial remainder. The remainder always stays below the divisor, so
   // it fits in WIDTH bits.
   always_comb begin
      w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
      w_shift = {r_hi, r_lo[WIDTH-1]};
      w_diff  = w_shift - {1'b0, r_b};
      if (r_isdiv) begin
         if (!w_diff[WIDTH]) begin
            w_hi_nxt = w_diff[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
         end else begin
            w_hi_nxt = w_shift[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         w_hi_nxt = w_sum[WIDTH:1];
         w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
      end
   end

   // Sign fix-up of the final iteration's values. The low word of a negated
   // double-width product depends only on the low word, so the full-width
   // negate is needed only when the upper word is exported.
   // The -2^(WIDTH-1) / -1 overflow case needs no special handling: its
   // magnitude quotient is already the required bit pattern.
   always_comb begin
      w_result = r_negres ? -w_lo_nxt : w_lo_nxt;
`ifdef MULDIV_HILO_EN
      w_prod = {w_hi_nxt, w_lo_nxt};
      if (r_negres) begin
         w_prod = -w_prod;
      end
      if (r_isdiv) begin
         w_hiresult = r_negrem ? -w_hi_nxt : w_hi_nxt;
      end else begin
         w_hiresult = w_prod[2*WIDTH-1:WIDTH];
      end
`endif
   end

   // Control FSM and the working/output registers.
   // A divide by zero skips every iteration. It spends a single pass-through
   // cycle in BUSY, so Done_o arrives two cycles after the request.
   always_ff @(posedge Clock_i) begin
      if (Reset_i) begin
         r_state   <= S_IDLE;
         r_count   <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_b       <= '0;
         r_isdiv   <= 1'b0;
         r_divz    <= 1'b0;
         r_negres  <= 1'b0;
         Result_o  <= '0;
         DivZero_o <= 1'b0;
`ifdef MULDIV_HILO_EN
         r_negrem  <= 1'b0;
         Hi_o      <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (Start_i) begin
                  r_state  <= S_BUSY;
                  r_hi     <= '0;
                  r_b      <= w_bmag;
                  r_isdiv  <= Op_i[1];
                  r_negres <= w_aneg ^ w_bneg;
`ifdef MULDIV_HILO_EN
                  r_negrem <= w_aneg;
`endif
                  if (Op_i[1] && (Data2_i == '0)) begin
                     r_divz  <= 1'b1;
                     r_count <= LAST;
                     r_lo    <= Data1_i;
                  end else begin
                     r_divz  <= 1'b0;
                     r_count <= '0;
                     r_lo    <= w_amag;
                  end
               end
            end
            S_BUSY: begin
               if (!r_divz) begin
                  r_hi <= w_hi_nxt;
                  r_lo <= w_lo_nxt;
               end
               r_count <= r_count + 1'b1;
               if (r_count == LAST) begin
                  r_state <= S_DONE;
                  if (r_divz) begin
                     Result_o  <= '1;
                     DivZero_o <= 1'b1;
`ifdef MULDIV_HILO_EN
                     Hi_o      <= r_lo;
`endif
                  end else begin
                     Result_o  <= w_result;
                     DivZero_o <= 1'b0;
`ifdef MULDIV_HILO_EN
                     Hi_o      <= w_hiresult;
`endif
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Stall is low in DONE so the pipeline advances and latches Result_o.
   always_comb begin
      Stall_o = (r_state == S_BUSY) | ((r_state == S_IDLE) & Start_i);
      Done_o  = (r_state == S_DONE);
   end

endmodule
